// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding and default operand width.
package mul_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/shift_add_mul_dp.sv
// Combinational add/shift step of the multiplier: one multiplier bit consumed per evaluation.
module shift_add_mul_dp
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_n,
    output logic [2*WIDTH-1:0] mcand_n,
    output logic [WIDTH-1:0]   mplier_n,
    output logic               mplier_zero
);

    always_comb begin
        acc_n       = acc + (mplier[0] ? mcand : '0);
        mcand_n     = mcand << 1;
        mplier_n    = mplier >> 1;
        mplier_zero = (mplier_n == '0);
    end

endmodule

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-and-add multiplier with start/done handshake.
// Optional EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are all zero.
module shift_add_mul
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e          state_q, state_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [PW-1:0]    acc_n;
    logic [PW-1:0]    mcand_n;
    logic [WIDTH-1:0] mplier_n;
    logic             mplier_zero;
    logic             last_cnt;
    logic             calc_exit;

    shift_add_mul_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .acc        (acc_q),
        .mcand      (mcand_q),
        .mplier     (mplier_q),
        .acc_n      (acc_n),
        .mcand_n    (mcand_n),
        .mplier_n   (mplier_n),
        .mplier_zero(mplier_zero)
    );

    assign last_cnt = (cnt_q == CW'(WIDTH - 1));

`ifdef EARLY_TERM_EN
    assign calc_exit = mplier_zero || last_cnt;
`else
    logic unused_mplier_zero;
    assign unused_mplier_zero = mplier_zero;
    assign calc_exit = last_cnt;
`endif

    // Next-state, datapath register updates and registered status outputs.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d  = PW'(a);
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d    = acc_n;
                mcand_d  = mcand_n;
                mplier_d = mplier_n;
                cnt_d    = cnt_q + CW'(1);
                if (calc_exit) begin
                    result_d = acc_n;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flops mirror the next state so they decode registered state with no extra lag.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// Scoreboard bench for shift_add_mul: accepted requests queue expected product and latency; a monitor checks each done.
module tb_shift_add_mul;

    localparam int unsigned W = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [2*W-1:0] result;

    shift_add_mul #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    typedef struct {
        logic [2*W-1:0] prod;
        int             e0;
        int             lat;
    } exp_t;

    exp_t           sb[$];
    int             total = 0;
    int             bad = 0;
    int             cyc = 0;
    logic [2*W-1:0] last_res = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic int model_lat(input logic [W-1:0] bv);
        int m;
        m = 0;
`ifdef EARLY_TERM_EN
        for (int i = 0; i < int'(W); i++)
            if (bv[i]) m = i + 1;
        if (m < 1) m = 1;
`else
        m = int'(W);
`endif
        return m;
    endfunction

    // Monitor first, then acceptance of a request at the upcoming edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_done got=1 want=0 cyc=%0d", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (result !== e.prod) begin
                        bad++;
                        $display("FAIL product got=%016h want=%016h", result, e.prod);
                    end
                    total++;
                    if (cyc - e.e0 != e.lat) begin
                        bad++;
                        $display("FAIL latency got=%0d want=%0d", cyc - e.e0, e.lat);
                    end
                    last_res = e.prod;
                end
            end else begin
                total++;
                if (result !== last_res) begin
                    bad++;
                    $display("FAIL result_hold got=%016h want=%016h", result, last_res);
                end
            end
            if (start && !busy) begin
                exp_t n;
                n.prod = 64'(a) * 64'(b);
                n.e0   = cyc + 1;
                n.lat  = model_lat(b);
                sb.push_back(n);
            end
        end
    end

    task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb);
        wait_idle();
        start = 1'b1;
        a     = aa;
        b     = bb;
        @(posedge clk);
        #2;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #23;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", result, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #2;

        issue(32'd3, 32'd5);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(32'd12345, 32'd0);
        issue(32'd0, $urandom);
        issue(32'd1, 32'h8000_0000);
        drain();

        // Start held high while operands churn; only operands at each acceptance count.
        start = 1'b1;
        for (int i = 0; i < 80; i++) begin
            a = $urandom;
            b = $urandom;
            @(posedge clk);
            #2;
        end
        start = 1'b0;
        drain();

        // Asynchronous abort in the middle of CALC.
        issue(32'hDEAD_BEEF, 32'hFFFF_FFFF);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_result", result, 64'd0);
        check("abort_done", 64'(done), 64'd0);
        sb.delete();
        last_res = '0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;
        issue(32'd7, 32'd6);
        drain();
        check("post_abort_product", result, 64'd42);

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = '0;
                1: rb = '0;
                2: ra = '1;
                3: rb = '1;
                4: rb = rb >> $urandom_range(0, 31);
                default: ;
            endcase
            issue(ra, rb);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
